keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/calc_pkg.sv | 46 ++++
 rtl/sync_2ff.sv | 30 +++
 rtl/keypad_scanner.sv | 112 +++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Calculator key types: matrix key vector, button struct, matrix-to-key map.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package calc_pkg;

  // One bit per matrix position, bit index = 4*row + col, 1 = closed.
  typedef logic [15:0] keys_t;

  typedef enum logic [3:0] {
    KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7, KEY_8, KEY_9,
    KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_EQ, KEY_CLR
  } key_e;

  // Field order makes the flattened bit index equal to the key_e code.
  typedef struct packed {
    logic       clr;
    logic       eq;
    logic       div;
    logic       mul;
    logic       sub;
    logic       add;
    logic [9:0] digit;
  } buttons_t;

  // Matrix layout, row 0 at the top:
  //   1 2 3 +
  //   4 5 6 -
  //   7 8 9 *
  //   C 0 = /
  localparam key_e KeyMap [16] = '{
    KEY_1,   KEY_2, KEY_3,  KEY_ADD,
    KEY_4,   KEY_5, KEY_6,  KEY_SUB,
    KEY_7,   KEY_8, KEY_9,  KEY_MUL,
    KEY_CLR, KEY_0, KEY_EQ, KEY_DIV
  };

  function automatic buttons_t keys_to_buttons(input keys_t keys);
    logic [15:0] vec;
    vec = '0;
    for (int i = 0; i < 16; i++) begin
      if (keys[i]) vec[KeyMap[i]] = 1'b1;
    end
    return buttons_t'(vec);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk_i cycles.
// Backpressure: none; free-running.
module sync_2ff #(
  parameter int          Width    = 4,
  parameter logic [Width-1:0] ResetVal = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Resolve metastability over two stages; reset to the idle (released) level.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with frame-level debounce feeding the calculator.
// Latency: press to buttons_o within (DebounceScans+1) frames + 3 cycles.
// Backpressure: none; key_event_o is a single-cycle pulse per stable change.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int ScanDivider   = 1000,
  parameter int DebounceScans = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  output logic [3:0] rows_o,
  input  logic [3:0] cols_i,
  output buttons_t buttons_o,
  output logic     key_event_o
);

  localparam int CntW   = (ScanDivider > 1) ? $clog2(ScanDivider) : 1;
  localparam int MatchW = $clog2(DebounceScans + 1);
  localparam logic [CntW-1:0]   SlotLast = CntW'(ScanDivider - 1);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(DebounceScans);

  // Rows must stay driven long enough for the column change to clear the synchronizer.
  if (ScanDivider < 4) begin : g_bad_divider
    $error("keypad_scanner: ScanDivider must be >= 4");
  end

  logic [3:0]        col_sync;
  logic              running_q;
  logic [CntW-1:0]   slot_cnt_q;
  logic [1:0]        row_q;
  logic [3:0]        rows_q;
  keys_t             snap_q;
  keys_t             prev_q;
  keys_t             stable_q;
  logic [MatchW-1:0] match_q;
  logic              key_event_q;

  logic              slot_last;
  logic              frame_end;
  logic [1:0]        row_d;
  keys_t             snap_d;
  logic [MatchW-1:0] match_d;

  sync_2ff #(
    .Width    (4),
    .ResetVal (4'hF)
  ) u_col_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (cols_i),
    .q_o   (col_sync)
  );

  // Slot/frame boundaries, the snapshot including the row being closed, next match count.
  always_comb begin
    slot_last = running_q && (slot_cnt_q == SlotLast);
    frame_end = slot_last && (row_q == 2'd3);
    row_d     = row_q + 2'd1;
    snap_d    = snap_q;
    snap_d[{row_q, 2'b00} +: 4] = ~col_sync;
    if (snap_d != prev_q) begin
      match_d = MatchW'(1);
    end else if (match_q == MatchMax) begin
      match_d = match_q;
    end else begin
      match_d = match_q + MatchW'(1);
    end
  end

  // Row scan sequencing, column sampling and frame-level debounce of the key vector.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      running_q   <= 1'b0;
      slot_cnt_q  <= '0;
      row_q       <= 2'd0;
      rows_q      <= 4'b1111;
      snap_q      <= '0;
      prev_q      <= '0;
      stable_q    <= '0;
      match_q     <= '0;
      key_event_q <= 1'b0;
    end else begin
      key_event_q <= 1'b0;
      if (!running_q) begin
        // First edge out of reset opens slot 0 of a fresh frame.
        running_q <= 1'b1;
        rows_q    <= 4'b1110;
      end else if (slot_last) begin
        slot_cnt_q <= '0;
        row_q      <= row_d;
        rows_q     <= ~(4'b0001 << row_d);
        snap_q     <= snap_d;
        if (frame_end) begin
          prev_q  <= snap_d;
          match_q <= match_d;
          if ((match_d == MatchMax) && (snap_d != stable_q)) begin
            stable_q    <= snap_d;
            key_event_q <= 1'b1;
          end
        end
      end else begin
        slot_cnt_q <= slot_cnt_q + CntW'(1);
      end
    end
  end

  assign rows_o      = rows_q;
  assign key_event_o = key_event_q;
  assign buttons_o   = keys_to_buttons(stable_q);

endmodule
